column_sequencer: RTL
=====================

COLUMN_SEQUENCER -- requirements
Module: column_sequencer

Interface
REQ-001 Parameter: TICK_DIV, default 25000000; clock cycles per row-advance step (>=2).
REQ-002 Parameter: MAX_MISS, default 8; miss count that ends the game (1..15).
REQ-003 CLOCK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 START  in  1  level; start/restart request, already synchronized.
REQ-006 KEY  in  4  level, one bit per column, already synchronized/debounced.
REQ-007 TARGET  in  4  current state of each column's target-row light.
REQ-008 STEP  out  1  one-cycle strobe; all column light chains advance one row.
REQ-009 SPAWN  out  4  feeds row 0 of each column; valid only in the STEP cycle.
REQ-010 GOTCHA  out  4  one-cycle clear to each column's target light; registered.
REQ-011 HITS  out  8  hit count, saturating.
REQ-012 MISSES  out  4  miss count, saturating.
REQ-013 PLAYING  out  1  high in PLAY state.
REQ-014 GAMEOVER  out  1  high in OVER state.

Function
REQ-015 FSM states IDLE, PLAY, OVER; PLAYING and GAMEOVER decode state directly.
REQ-016 IDLE->PLAY and OVER->PLAY when START=1; START is ignored in PLAY.
REQ-017 On an IDLE/OVER->PLAY transition: HITS=0, MISSES=0, tick counter=0, LFSR=8'hA5, GOTCHA=4'b1111 for exactly one cycle (board clear).
REQ-018 PLAY->OVER on the edge where the updated MISSES value is >= MAX_MISS; no STEP, SPAWN or GOTCHA is generated after that.
REQ-019 Tick counter counts 0..TICK_DIV-1 in PLAY only; STEP=1 in the cycle the count equals TICK_DIV-1, and the counter wraps to 0; counter holds at 0 outside PLAY.
REQ-020 LFSR: 8-bit Fibonacci, shifts left, new bit0 = b7^b5^b4^b3; advances only on STEP cycles.
REQ-021 SPAWN = one-hot(lfsr[1:0]) when STEP=1 and lfsr[2]=1, else 4'b0000 (current LFSR value, before advancing).
REQ-022 Press detect: KEY_q registers KEY every cycle; press[i] = KEY[i] & ~KEY_q[i]; held keys generate no further presses.
REQ-023 Hit: press[i] & TARGET[i] in PLAY -> GOTCHA[i]=1 in the following cycle only; HITS += popcount(hits), saturating at 255.
REQ-024 Wrong press: press[i] & ~TARGET[i] in PLAY counts one miss for column i.
REQ-025 Missed note: in a STEP cycle, TARGET[i]=1 with no hit on column i in that cycle counts one miss; a hit in the same cycle takes precedence.
REQ-026 Each cycle, MISSES += total miss events (0..4), saturating at 15; HITS and MISSES update on the same edge as the corresponding GOTCHA asserts.
REQ-027 Outside PLAY: STEP=0, SPAWN=0, and GOTCHA=0 except for the REQ-017 pulse; counters hold.

Reset
REQ-028 RESET=0 asynchronously forces state=IDLE, tick counter=0, LFSR=8'hA5, KEY_q=0, STEP=0, SPAWN=0, GOTCHA=0, HITS=0, MISSES=0.
REQ-029 Reset in mid-game discards any pending GOTCHA or counter update; the block resumes in IDLE on the first edge after RESET=1.

Structure
REQ-030 The shared package ddr_pkg SHALL hold the state encoding, the column count (4), the LFSR seed 8'hA5 and the tap mask.
REQ-031 The tick counter and STEP strobe SHALL be one sub-module, step_timer (ports CLOCK, RESET, EN, STEP); all other logic stays in column_sequencer.

Verification
REQ-032 Reset, then START=1 for 1 cycle -> PLAYING=1 and GOTCHA=4'b1111 for 1 cycle; HITS=0, MISSES=0.
REQ-033 TICK_DIV=4 in PLAY -> STEP pulses every 4th cycle; first SPAWN follows the LFSR sequence from 8'hA5 (lfsr[2]=1, lfsr[1:0]=01 -> SPAWN=4'b0010).
REQ-034 TARGET=4'b0100 and KEY[2] rises -> GOTCHA=4'b0100 for 1 cycle and HITS=1; holding KEY[2] gives no second hit.
REQ-035 TARGET=4'b0001 at STEP and KEY[0] rises in the same cycle -> hit only, MISSES unchanged; with no press -> MISSES+1.
REQ-036 MAX_MISS=2: two wrong presses -> GAMEOVER=1, STEP stops; START -> PLAY with counters cleared. RESET=0 mid-game -> all outputs at REQ-028 values immediately.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the column sequencer: game states, column count,
// LFSR seed/taps and small helper functions.
package ddr_pkg;

    localparam int unsigned NUM_COLS  = 4;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    // Feedback taps b7, b5, b4, b3
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Fibonacci LFSR step: shift left, parity of tapped bits enters at bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    // Number of set bits in a per-column mask
    function automatic logic [2:0] popcount_cols(input logic [NUM_COLS-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Row-advance timer: counts clock cycles while enabled and strobes STEP on
// the last cycle of each TICK_DIV period. Held at zero while disabled.
module step_timer #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic EN,
    output logic STEP
);

    localparam int unsigned    CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Strobe on terminal count, wrap to zero; clear whenever disabled
    always_comb begin
        STEP  = EN && (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        if (!EN || STEP) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/column_sequencer.sv
// Four-column rhythm game sequencer: game FSM, note spawning from an LFSR,
// key press detection, hit/miss scoring and target-light clearing.
module column_sequencer
    import ddr_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned MAX_MISS = 8
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                START,
    input  logic [NUM_COLS-1:0] KEY,
    input  logic [NUM_COLS-1:0] TARGET,
    output logic                STEP,
    output logic [NUM_COLS-1:0] SPAWN,
    output logic [NUM_COLS-1:0] GOTCHA,
    output logic [7:0]          HITS,
    output logic [3:0]          MISSES,
    output logic                PLAYING,
    output logic                GAMEOVER
);

    localparam logic [3:0] MAX_MISS_C = 4'(MAX_MISS);

    state_e              state_q;
    logic [7:0]          lfsr_q;
    logic [NUM_COLS-1:0] key_q;
    logic [NUM_COLS-1:0] gotcha_q;
    logic [7:0]          hits_q;
    logic [3:0]          misses_q;

    logic                step;
    logic [NUM_COLS-1:0] press;
    logic [NUM_COLS-1:0] hit;
    logic [NUM_COLS-1:0] wrong;
    logic [NUM_COLS-1:0] late;
    logic [8:0]          hits_sum;
    logic [4:0]          miss_sum;
    logic [7:0]          hits_d;
    logic [3:0]          misses_d;
    logic                game_end;

    step_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_step_timer (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .EN   (state_q == ST_PLAY),
        .STEP (step)
    );

    // Press/hit/miss classification and saturating score arithmetic
    always_comb begin
        press = KEY & ~key_q;
        hit   = press & TARGET;
        wrong = press & ~TARGET;
        // A lit target that is not hit on the step cycle scrolls away as a miss
        late  = step ? (TARGET & ~hit) : '0;

        hits_sum = {1'b0, hits_q} + {6'd0, popcount_cols(hit)};
        miss_sum = {1'b0, misses_q} + {2'd0, popcount_cols(wrong)} + {2'd0, popcount_cols(late)};
        hits_d   = hits_sum[8] ? 8'hFF : hits_sum[7:0];
        misses_d = miss_sum[4] ? 4'hF  : miss_sum[3:0];
        game_end = (misses_d >= MAX_MISS_C);

        SPAWN = '0;
        if (step && lfsr_q[2]) begin
            SPAWN = NUM_COLS'(1) << lfsr_q[1:0];
        end
    end

    // Game FSM with registered score, LFSR and target-clear outputs
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= LFSR_SEED;
            key_q    <= '0;
            gotcha_q <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            key_q    <= KEY;
            gotcha_q <= '0;
            case (state_q)
                ST_PLAY: begin
                    hits_q   <= hits_d;
                    misses_q <= misses_d;
                    if (step) begin
                        lfsr_q <= lfsr_next(lfsr_q);
                    end
                    // Ending edge suppresses the clear pulse so nothing fires in OVER
                    if (game_end) begin
                        state_q <= ST_OVER;
                    end else begin
                        gotcha_q <= hit;
                    end
                end
                default: begin
                    if (START) begin
                        state_q  <= ST_PLAY;
                        hits_q   <= '0;
                        misses_q <= '0;
                        lfsr_q   <= LFSR_SEED;
                        gotcha_q <= '1;
                    end
                end
            endcase
        end
    end

    assign STEP     = step;
    assign GOTCHA   = gotcha_q;
    assign HITS     = hits_q;
    assign MISSES   = misses_q;
    assign PLAYING  = (state_q == ST_PLAY);
    assign GAMEOVER = (state_q == ST_OVER);

endmodule
